// File: rtl/uart_pkg.sv
// Shared types, parity encodings and helpers for the parametrised UART.
// Imported by the tick divider and the core.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Bits needed to hold value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return (result < 1) ? 1 : result;
  endfunction

  // Mode 2'b11 is deliberately treated like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_if.sv
// Host-side handshake bundle of the UART.
// The host drives the TX offer; the core drives TX ready and the RX result.
interface uart_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_tick_div.sv
// Loadable down-counting divider: one tick every div_i+1 enabled clocks.
// A load restarts the period from the supplied divisor.
module uart_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? div_i : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: runtime divisor, 5..9 data bits, none/even/odd parity,
// 1 or 2 TX stop bits, valid/ready TX and pulsed RX with error flags.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic             txd,
  input  logic             rxd,
  uart_if.slave            host
);

  localparam int OS_W  = clog2(OVERSAMPLE);
  localparam int BIT_W = clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [OS_W-1:0]      tx_os_q, tx_os_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_bit_q, tx_par_bit_d;
  logic                 tx_par_en_q, tx_par_en_d;
  logic                 tx_stop2_q, tx_stop2_d;
  logic [DIV_W-1:0]     tx_div_q, tx_div_d;
  logic                 txd_q, txd_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_tick, tx_accept, tx_bit_end;

  assign tx_accept  = host.tx_valid && tx_ready_q;
  assign tx_bit_end = tx_tick && (tx_os_q == OS_LAST);

  // The divisor is taken live only on the acceptance edge, latched afterwards.
  uart_tick_div #(.DIV_W(DIV_W)) u_tx_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (tx_state_q != TX_IDLE),
    .load_i (tx_accept),
    .div_i  (tx_accept ? cfg_div : tx_div_q),
    .tick_o (tx_tick)
  );

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_os_d      = tx_os_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_par_en_d  = tx_par_en_q;
    tx_stop2_d   = tx_stop2_q;
    tx_div_d     = tx_div_q;
    if (tx_tick) tx_os_d = (tx_os_q == OS_LAST) ? '0 : tx_os_q + OS_W'(1);
    case (tx_state_q)
      TX_IDLE: if (tx_accept) begin
        tx_state_d   = TX_START;
        tx_os_d      = '0;
        tx_bit_d     = '0;
        tx_shift_d   = host.tx_data;
        tx_par_en_d  = parity_enabled(cfg_parity);
        tx_par_bit_d = (^host.tx_data) ^ (cfg_parity == PAR_ODD);
        tx_stop2_d   = cfg_stop2;
        tx_div_d     = cfg_div;
      end
      TX_START:  if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == BIT_LAST) tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
        else                      tx_bit_d   = tx_bit_q + BIT_W'(1);
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP1;
      TX_STOP1:  if (tx_bit_end) tx_state_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
      TX_STOP2:  if (tx_bit_end) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
    // Pin and ready are registered from the next state so txd never glitches.
    case (tx_state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_shift_d[0];
      TX_PARITY: txd_d = tx_par_bit_d;
      default:   txd_d = 1'b1;
    endcase
    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q   <= TX_IDLE;
      tx_os_q      <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_bit_q <= 1'b0;
      tx_par_en_q  <= 1'b0;
      tx_stop2_q   <= 1'b0;
      tx_div_q     <= '0;
      txd_q        <= 1'b1;
      tx_ready_q   <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_os_q      <= tx_os_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_bit_q <= tx_par_bit_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_stop2_q   <= tx_stop2_d;
      tx_div_q     <= tx_div_d;
      txd_q        <= txd_d;
      tx_ready_q   <= tx_ready_d;
    end
  end

  assign txd           = txd_q;
  assign host.tx_ready = tx_ready_q;

  // ---------------- receiver ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [OS_W-1:0]      rx_os_q, rx_os_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [1:0]           rx_par_q, rx_par_d;
  logic                 rx_perr_pend_q, rx_perr_pend_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_tick, rx_sample;

  uart_tick_div #(.DIV_W(DIV_W)) u_rx_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .load_i (1'b0),
    .div_i  (cfg_div),
    .tick_o (rx_tick)
  );

  assign rx_sample = rx_tick && (rx_os_q == OS_LAST);

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_os_d        = rx_os_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_par_d       = rx_par_q;
    rx_perr_pend_d = rx_perr_pend_q;
    rx_valid_d     = 1'b0;
    rx_data_d      = rx_data_q;
    rx_perr_d      = rx_perr_q;
    rx_ferr_d      = rx_ferr_q;
    if (rx_tick && (rx_state_q == RX_DATA || rx_state_q == RX_PARITY || rx_state_q == RX_STOP))
      rx_os_d = (rx_os_q == OS_LAST) ? '0 : rx_os_q + OS_W'(1);
    case (rx_state_q)
      RX_IDLE: if (rx_tick && !rx_sync_q) begin
        rx_state_d     = RX_START;
        rx_os_d        = '0;
        rx_par_d       = cfg_parity;
        rx_perr_pend_d = 1'b0;
      end
      RX_START: if (rx_tick) begin
        if (rx_os_q == OS_HALF) begin
          rx_os_d    = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_os_d = rx_os_q + OS_W'(1);
        end
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == BIT_LAST) rx_state_d = parity_enabled(rx_par_q) ? RX_PARITY : RX_STOP;
        else                      rx_bit_d   = rx_bit_q + BIT_W'(1);
      end
      RX_PARITY: if (rx_sample) begin
        rx_perr_pend_d = rx_sync_q ^ (^rx_shift_q) ^ (rx_par_q == PAR_ODD);
        rx_state_d     = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_valid_d = 1'b1;
        rx_data_d  = rx_shift_q;
        rx_perr_d  = parity_enabled(rx_par_q) && rx_perr_pend_q;
        rx_ferr_d  = !rx_sync_q;
        // A low stop bit may be a break: wait for the line to return high.
        rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_tick && rx_sync_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_os_q        <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_par_q       <= PAR_NONE;
      rx_perr_pend_q <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      rx_perr_q      <= 1'b0;
      rx_ferr_q      <= 1'b0;
    end else begin
      rx_meta_q      <= rxd;
      rx_sync_q      <= rx_meta_q;
      rx_state_q     <= rx_state_d;
      rx_os_q        <= rx_os_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_par_q       <= rx_par_d;
      rx_perr_pend_q <= rx_perr_pend_d;
      rx_valid_q     <= rx_valid_d;
      rx_data_q      <= rx_data_d;
      rx_perr_q      <= rx_perr_d;
      rx_ferr_q      <= rx_ferr_d;
    end
  end

  assign host.rx_valid      = rx_valid_q;
  assign host.rx_data       = rx_data_q;
  assign host.rx_parity_err = rx_perr_q;
  assign host.rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX waveform and RX results compared
// against a bit-list frame model built from data, parity mode and stop bits.
module tb_uart_core;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic [1:0]    cfg_parity = 2'b00;
  logic          cfg_stop2 = 1'b0;
  logic          txd;
  logic          rxd;
  logic          rxd_drv = 1'b1;
  logic          loop_en = 1'b1;

  int total = 0;
  int bad = 0;

  int            rx_cnt = 0;
  logic [DB-1:0] rx_last_data = '0;
  logic          rx_last_pe = 1'b0;
  logic          rx_last_fe = 1'b0;

  uart_if #(.DATA_BITS(DB)) host ();

  assign rxd = loop_en ? txd : rxd_drv;

  uart_core #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .txd        (txd),
    .rxd        (rxd),
    .host       (host)
  );

  always #5 clk = ~clk;

  // Counting on the falling edge sees each one-clock pulse exactly once.
  always @(negedge clk) begin
    if (host.rx_valid === 1'b1) begin
      rx_cnt       <= rx_cnt + 1;
      rx_last_data <= host.rx_data;
      rx_last_pe   <= host.rx_parity_err;
      rx_last_fe   <= host.rx_frame_err;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic model_parity(input logic [DB-1:0] d, input logic [1:0] par);
    logic odd_ones;
    odd_ones = ($countones(d) % 2) == 1;
    return (par == 2'b10) ? !odd_ones : odd_ones;
  endfunction

  function automatic logic model_par_on(input logic [1:0] par);
    return (par == 2'b01) || (par == 2'b10);
  endfunction

  task automatic send_check(input logic [DB-1:0] d, input logic [1:0] par,
                            input logic stop2, input int div);
    logic [15:0] bits;
    int n, bl, mism, waited, c0;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < DB; i++) begin bits[n] = d[i]; n++; end
    if (model_par_on(par)) begin bits[n] = model_parity(d, par); n++; end
    bits[n] = 1'b1; n++;
    if (stop2) begin bits[n] = 1'b1; n++; end
    bl = OS * (div + 1);

    loop_en = 1'b1;
    cfg_div = DW'(div);
    cfg_parity = par;
    cfg_stop2 = stop2;
    waited = 0;
    while (host.tx_ready !== 1'b1 && waited < 2000) begin step(); waited++; end
    check("tx_ready_before_send", 32'(host.tx_ready), 32'd1);
    c0 = rx_cnt;
    host.tx_valid = 1'b1;
    host.tx_data = d;
    step();
    host.tx_valid = 1'b0;
    host.tx_data = DB'($urandom);
    cfg_stop2 = !stop2;
    mism = 0;
    for (int k = 0; k < n * bl; k++) begin
      if (txd !== bits[k / bl] || host.tx_ready !== 1'b0) mism++;
      step();
    end
    check("tx_waveform", 32'(mism), 32'd0);
    check("tx_ready_at_frame_end", 32'(host.tx_ready), 32'd1);
    check("txd_idle_after_frame", 32'(txd), 32'd1);
    repeat (bl) step();
    check("loop_rx_count", 32'(rx_cnt - c0), 32'd1);
    check("loop_rx_data", 32'(rx_last_data), 32'(d));
    check("loop_rx_parity_err", 32'(rx_last_pe), 32'd0);
    check("loop_rx_frame_err", 32'(rx_last_fe), 32'd0);
    $display("tx frame data=%02h par=%0d stop2=%0b div=%0d bits=%0d -> rx data=%02h pe=%0b fe=%0b",
             d, par, stop2, div, n, rx_last_data, rx_last_pe, rx_last_fe);
  endtask

  task automatic rx_frame(input logic [DB-1:0] d, input logic [1:0] par, input logic pbit,
                          input logic stopb, input int div, input int tail, input logic tail_lvl);
    logic [15:0] bits;
    int n, bl, c0;
    logic exp_pe;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < DB; i++) begin bits[n] = d[i]; n++; end
    if (model_par_on(par)) begin bits[n] = pbit; n++; end
    bits[n] = stopb; n++;
    exp_pe = model_par_on(par) && (pbit != model_parity(d, par));
    bl = OS * (div + 1);

    loop_en = 1'b0;
    cfg_div = DW'(div);
    cfg_parity = par;
    c0 = rx_cnt;
    for (int i = 0; i < n; i++) begin
      rxd_drv = bits[i];
      repeat (bl) step();
    end
    rxd_drv = tail_lvl;
    repeat (tail) step();
    check("rx_count", 32'(rx_cnt - c0), 32'd1);
    check("rx_data", 32'(rx_last_data), 32'(d));
    check("rx_parity_err", 32'(rx_last_pe), 32'(exp_pe));
    check("rx_frame_err", 32'(rx_last_fe), 32'(!stopb));
    $display("rx frame data=%02h par=%0d pbit=%0b stop=%0b div=%0d -> data=%02h pe=%0b fe=%0b",
             d, par, pbit, stopb, div, rx_last_data, rx_last_pe, rx_last_fe);
  endtask

  initial begin
    int c0, dv;
    logic [DB-1:0] d;
    logic [1:0] p;
    host.tx_valid = 1'b0;
    host.tx_data = '0;

    // Reset state
    repeat (3) step();
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_tx_ready", 32'(host.tx_ready), 32'd0);
    check("reset_rx_valid", 32'(host.rx_valid), 32'd0);
    check("reset_rx_data", 32'(host.rx_data), 32'd0);
    check("reset_rx_parity_err", 32'(host.rx_parity_err), 32'd0);
    check("reset_rx_frame_err", 32'(host.rx_frame_err), 32'd0);
    rst_n = 1'b1;
    step();
    check("tx_ready_after_release", 32'(host.tx_ready), 32'd1);
    $display("reset released");

    // Directed loopback frames
    send_check(8'hA5, 2'b00, 1'b0, 0);
    send_check(8'h07, 2'b01, 1'b1, 0);
    send_check(8'h07, 2'b10, 1'b1, 0);

    // Randomised loopback frames
    repeat (6) begin
      send_check(DB'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)));
    end

    // Parity error: 0x07 carries an even-parity bit of 0
    rx_frame(8'h07, 2'b01, 1'b0, 1'b1, 0, 20, 1'b1);

    // Framing error followed by a held-low line
    rx_frame(8'h3C, 2'b00, 1'b0, 1'b0, 0, 40, 1'b0);
    c0 = rx_cnt;
    rxd_drv = 1'b1;
    repeat (40) step();
    check("no_rx_after_break", 32'(rx_cnt - c0), 32'd0);
    rx_frame(8'h81, 2'b00, 1'b0, 1'b1, 0, 20, 1'b1);

    // Short low glitch is a false start
    loop_en = 1'b0;
    cfg_div = '0;
    c0 = rx_cnt;
    rxd_drv = 1'b0;
    repeat (4) step();
    rxd_drv = 1'b1;
    repeat (40) step();
    check("false_start_no_rx", 32'(rx_cnt - c0), 32'd0);
    $display("false start glitch -> rx pulses=%0d", rx_cnt - c0);
    rx_frame(DB'($urandom), 2'b00, 1'b0, 1'b1, 0, 20, 1'b1);

    // Randomised RX frames, including wrong parity bits and low stop bits
    repeat (6) begin
      d = DB'($urandom);
      p = 2'($urandom_range(0, 3));
      dv = int'($urandom_range(0, 1));
      rx_frame(d, p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
               dv, 2 * OS * (dv + 1), 1'b1);
    end

    // Reset during TX data bit 3
    loop_en = 1'b1;
    cfg_div = '0;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    host.tx_valid = 1'b1;
    host.tx_data = 8'h5A;
    step();
    host.tx_valid = 1'b0;
    repeat (4 * OS + 7) step();
    check("txd_is_data_bit3", 32'(txd), 32'd1);
    c0 = rx_cnt;
    rst_n = 1'b0;
    step();
    check("midframe_reset_txd", 32'(txd), 32'd1);
    check("midframe_reset_tx_ready", 32'(host.tx_ready), 32'd0);
    check("midframe_reset_rx_data", 32'(host.rx_data), 32'd0);
    rst_n = 1'b1;
    step();
    check("midframe_release_tx_ready", 32'(host.tx_ready), 32'd1);
    repeat (40) step();
    check("no_partial_rx_after_reset", 32'(rx_cnt - c0), 32'd0);
    $display("reset during tx bit 3 -> rx pulses=%0d", rx_cnt - c0);
    send_check(DB'($urandom), 2'b01, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
